fp_mul_scheduler: RTL and testbench
===================================

// Module: fp_mul_scheduler
// PURPOSE
//  Shares one FloatingMultiplication unit (IEEE-754 single) between NREQ requesters.
//  Round-robin arbitration, per-requester valid/ready on request and response.
//  Sequences the multiplier's EN and waits for Flag_Mul.
//  Returns the product with the zero/infinity flags to the requester that issued it.
// PARAMETERS
//  NREQ      4   number of requesters, 2..8
//  W        32   operand/result width; fixed single precision
//  TIMEOUT  15   cycles in WAIT before abort; used only with FP_MUL_TIMEOUT_EN
// PORTS
//  CLK        in   1        clock, rising edge
//  RST        in   1        asynchronous reset, active-low
//  req_valid  in   NREQ     request pending, one bit per requester
//  req_a      in   NREQ*W   operand A of requester i at [i*W +: W]
//  req_b      in   NREQ*W   operand B of requester i at [i*W +: W]
//  req_ready  out  NREQ     one-hot accept pulse
//  rsp_valid  out  NREQ     one-hot; result available for that requester
//  rsp_ready  in   NREQ     requester consumes the result
//  rsp_data   out  W        product
//  rsp_zero   out  1        product is zero
//  rsp_inf    out  1        product is infinity
//  rsp_err    out  1        multiplier timed out; rsp_data = 32'h7FC00000
//  mul_A      out  W        multiplier operand A, registered
//  mul_B      out  W        multiplier operand B, registered
//  mul_EN     out  1        multiplier enable
//  mul_out    in   W        multiplier OUT_MUL
//  mul_flag   in   1        multiplier Flag_Mul (result done)
//  mul_zero   in   1        multiplier zero flag
//  mul_inf    in   1        multiplier infinity flag
// BEHAVIOUR
//  Reset (RST=0, async): all outputs 0, state IDLE, rr pointer = NREQ-1 (req 0 has top priority).
//  IDLE:
//   - If any req_valid, grant g = first set bit at or after (ptr+1) mod NREQ.
//   - Same cycle: req_ready[g]=1, operands latched into mul_A/mul_B, go ISSUE.
//  ISSUE: mul_EN=1; mul_flag ignored (may be stale from the previous op); go WAIT.
//  WAIT: mul_EN stays 1. On the first edge with mul_flag=1:
//   - capture mul_out/mul_zero/mul_inf into rsp_*, rsp_err=0, go RESP.
//  RESP:
//   - rsp_valid[g]=1, and rsp_* held stable until rsp_ready[g]=1.
//   - Then ptr=g, rsp_valid=0, go IDLE. Other bits of rsp_ready are ignored.
//  Minimum latency: accept at cycle 0; rsp_valid at cycle 2 + multiplier latency.
//  Throughput: one op in flight; next grant earliest the cycle after the RESP handshake.
//  Requesters hold req_a/req_b stable while req_valid=1 and not accepted.
//   - Dropping req_valid before grant is legal.
//  req_valid changing in the grant cycle: the grant uses the values sampled at that edge.
//  Reset mid-op: operation discarded, no response, multiplier EN dropped immediately.
//  ptr wraps NREQ-1 -> 0.
// CONFIGURATION
//  FP_MUL_TIMEOUT_EN defined:
//   - 5-bit counter cleared on entering WAIT.
//   - After TIMEOUT cycles without mul_flag: rsp_data=32'h7FC00000, rsp_zero=rsp_inf=0,
//     rsp_err=1, go RESP.
//  Undefined: no counter; WAIT is held indefinitely; rsp_err tied 0.
// STRUCTURE
//  Package fp_mul_pkg:
//   - state enum {IDLE, ISSUE, WAIT, RESP}
//   - FP_QNAN = 32'h7FC00000
//   - FP_W = 32
//  Sub-module fp_rr_arbiter (NREQ): inputs req vector + ptr; outputs one-hot grant + index.
//  Purely combinational.
// TESTING
//  1. After reset, req_valid=4'b1111 -> grants in order 0,1,2,3,0.
//     Each rsp_valid is one-hot on the matching bit.
//  2. Req1 A=41B26666 (22.3), B=BF000000 (-0.5); multiplier model flags after 3 cycles
//     -> rsp_valid[1] at cycle 5; rsp_data = C1326666 (-11.15).
//  3. A=7F800000 (+inf), B=404CCCCC; model asserts infinity -> rsp_inf=1, rsp_data=7F800000.
//  4. rsp_ready held 0 for 10 cycles with req0 pending -> rsp_* stable; req_ready stays 0.
//     Release rsp_ready -> next grant the cycle after.
//  5. Timeout (macro on, TIMEOUT=15): mul_flag never set -> rsp_err=1, rsp_data=7FC00000.
//     rsp_valid asserted 17 cycles after accept.
//  6. RST pulled low during WAIT -> all outputs 0 asynchronously.
//     After release, first grant goes to req0.

Source files
------------

// File: rtl/fp_mul_pkg.sv
// Shared types and constants for the floating-point multiplier scheduler.
package fp_mul_pkg;

   localparam int unsigned FP_W = 32;
   localparam logic [FP_W-1:0] FP_QNAN = 32'h7FC00000;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      RESP
   } state_e;

   // Index width for an n-entry one-hot vector; never narrower than one bit.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/fp_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first request at or after ptr+1.
module fp_rr_arbiter
   import fp_mul_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   localparam int unsigned IW = idx_w(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IW-1:0]   ptr,
   output logic [NREQ-1:0] grant,
   output logic [IW-1:0]   index
);

   logic           found;
   int unsigned    pos;
   logic [IW-1:0]  pos_i;

   // Walk the requesters starting just past the pointer, wrapping modulo NREQ.
   always_comb begin
      grant = '0;
      index = '0;
      found = 1'b0;
      pos   = 0;
      pos_i = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         pos   = (32'(ptr) + k) % NREQ;
         pos_i = IW'(pos);
         if (!found && req[pos_i]) begin
            found        = 1'b1;
            grant[pos_i] = 1'b1;
            index        = pos_i;
         end
      end
   end

endmodule

// File: rtl/fp_mul_scheduler.sv
// Shares one single-precision multiplier between NREQ round-robin requesters.
// Optional multiplier watchdog enabled by defining FP_MUL_TIMEOUT_EN.
module fp_mul_scheduler
   import fp_mul_pkg::*;
#(
   parameter int unsigned NREQ = 4,
   parameter int unsigned W    = FP_W
`ifdef FP_MUL_TIMEOUT_EN
   ,
   parameter int unsigned TIMEOUT = 15
`endif
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   output logic [NREQ-1:0]   req_ready,
   output logic [NREQ-1:0]   rsp_valid,
   input  logic [NREQ-1:0]   rsp_ready,
   output logic [W-1:0]      rsp_data,
   output logic              rsp_zero,
   output logic              rsp_inf,
   output logic              rsp_err,
   output logic [W-1:0]      mul_A,
   output logic [W-1:0]      mul_B,
   output logic              mul_EN,
   input  logic [W-1:0]      mul_out,
   input  logic              mul_flag,
   input  logic              mul_zero,
   input  logic              mul_inf
);

   localparam int unsigned IW = idx_w(NREQ);

   state_e           state;
   logic [IW-1:0]    ptr;
   logic [IW-1:0]    cur;
   logic [NREQ-1:0]  cur_oh;
   logic [NREQ-1:0]  arb_grant;
   logic [IW-1:0]    arb_idx;

   fp_rr_arbiter #(
      .NREQ (NREQ)
   ) u_arb (
      .req   (req_valid),
      .ptr   (ptr),
      .grant (arb_grant),
      .index (arb_idx)
   );

`ifdef FP_MUL_TIMEOUT_EN
   localparam logic [4:0] TO_LAST = 5'(TIMEOUT);
   logic [4:0] tmo_cnt;
   logic       err_q;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // Single-op sequencer: grant, enable multiplier, wait for done, hand result back.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         ptr       <= IW'(NREQ - 1);
         cur       <= '0;
         cur_oh    <= '0;
         req_ready <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
         rsp_zero  <= 1'b0;
         rsp_inf   <= 1'b0;
         mul_A     <= '0;
         mul_B     <= '0;
         mul_EN    <= 1'b0;
`ifdef FP_MUL_TIMEOUT_EN
         tmo_cnt   <= '0;
         err_q     <= 1'b0;
`endif
      end else begin
         req_ready <= '0;
         case (state)
            IDLE: begin
               if (|req_valid) begin
                  req_ready <= arb_grant;
                  cur       <= arb_idx;
                  cur_oh    <= arb_grant;
                  mul_A     <= req_a[32'(arb_idx)*W +: W];
                  mul_B     <= req_b[32'(arb_idx)*W +: W];
                  mul_EN    <= 1'b1;
                  state     <= ISSUE;
               end
            end
            // mul_flag may still reflect the previous op here, so it is not looked at.
            ISSUE: begin
`ifdef FP_MUL_TIMEOUT_EN
               tmo_cnt <= '0;
`endif
               state <= WAIT;
            end
            WAIT: begin
               if (mul_flag) begin
                  rsp_data  <= mul_out;
                  rsp_zero  <= mul_zero;
                  rsp_inf   <= mul_inf;
`ifdef FP_MUL_TIMEOUT_EN
                  err_q     <= 1'b0;
`endif
                  mul_EN    <= 1'b0;
                  rsp_valid <= cur_oh;
                  state     <= RESP;
               end
`ifdef FP_MUL_TIMEOUT_EN
               else if (tmo_cnt == TO_LAST) begin
                  rsp_data  <= W'(FP_QNAN);
                  rsp_zero  <= 1'b0;
                  rsp_inf   <= 1'b0;
                  err_q     <= 1'b1;
                  mul_EN    <= 1'b0;
                  rsp_valid <= cur_oh;
                  state     <= RESP;
               end else begin
                  tmo_cnt <= tmo_cnt + 5'd1;
               end
`endif
            end
            RESP: begin
               if (|(rsp_ready & cur_oh)) begin
                  ptr       <= cur;
                  rsp_valid <= '0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_scheduler.sv
// Scoreboard bench for fp_mul_scheduler with a behavioural multiplier model.
// Timeout scenario runs only when FP_MUL_TIMEOUT_EN is defined.
module tb_fp_mul_scheduler;
   import fp_mul_pkg::*;

   localparam int unsigned NREQ = 4;
   localparam int unsigned W    = 32;

   logic              CLK;
   logic              RST;
   logic [NREQ-1:0]   req_valid, req_ready, rsp_valid, rsp_ready;
   logic [NREQ*W-1:0] req_a, req_b;
   logic [W-1:0]      rsp_data, mul_A, mul_B, mul_out;
   logic              rsp_zero, rsp_inf, rsp_err;
   logic              mul_EN, mul_flag, mul_zero, mul_inf;

   typedef struct {
      int          idx;
      logic [31:0] data;
      logic        zero;
      logic        inf;
      logic        err;
   } exp_t;

   exp_t sb[$];
   int   grant_log[$];
   int   n_checks = 0;
   int   n_errors = 0;
   int   cyc = 0;
   int   acc_cyc = 0, rsp_cyc = 0, hs_cyc = 0, n_rsp = 0;
   bit   rsp_seen = 0, rv_prev = 0, exp_timeout = 0, mdl_hang = 0;
   int   mdl_cnt = 0;
   int   mdl_lat = 3;
   int   m_idx;
   exp_t m_e;
   logic [33:0] m_r;
   logic [33:0] mdl_res;

   fp_mul_scheduler #(.NREQ(NREQ), .W(W)) dut (
      .CLK(CLK), .RST(RST),
      .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_zero(rsp_zero), .rsp_inf(rsp_inf), .rsp_err(rsp_err),
      .mul_A(mul_A), .mul_B(mul_B), .mul_EN(mul_EN), .mul_out(mul_out),
      .mul_flag(mul_flag), .mul_zero(mul_zero), .mul_inf(mul_inf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Multiplier model result: {zero, inf, product}; only the cases the bench uses are exact.
   function automatic logic [33:0] mdl_mul(input logic [31:0] a, input logic [31:0] b);
      logic s;
      logic [33:0] r;
      s = a[31] ^ b[31];
      if (a[30:0] == 31'd0 || b[30:0] == 31'd0)
         r = {1'b1, 1'b0, s, 31'd0};
      else if ((a[30:23] == 8'hFF && a[22:0] == 23'd0) || (b[30:23] == 8'hFF && b[22:0] == 23'd0))
         r = {1'b0, 1'b1, s, 8'hFF, 23'd0};
      else if (a == 32'h41B26666 && b == 32'hBF000000)
         r = {2'b00, 32'hC1326666};
      else
         r = {2'b00, a ^ b};
      return r;
   endfunction

   // Done flag rises after the enable has been held for more than mdl_lat edges.
   always @(posedge CLK) begin
      if (!mul_EN) mdl_cnt <= 0;
      else mdl_cnt <= mdl_cnt + 1;
   end
   assign mul_flag = mul_EN && !mdl_hang && (mdl_cnt > mdl_lat);
   assign mdl_res  = mdl_mul(mul_A, mul_B);
   assign mul_zero = mdl_res[33];
   assign mul_inf  = mdl_res[32];
   assign mul_out  = mdl_res[31:0];

   // Monitor: push expectation on each accept, pop and compare on each response handshake.
   always @(negedge CLK) begin
      if (!RST) begin
         rv_prev = 1'b0;
      end else begin
         if (req_ready !== '0) begin
            n_checks++;
            if (!$onehot(req_ready)) begin
               n_errors++;
               $display("FAIL accept_onehot req_ready=%b required one-hot", req_ready);
            end
            m_idx = 0;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) m_idx = i;
            m_r = mdl_mul(req_a[m_idx*W +: W], req_b[m_idx*W +: W]);
            m_e.idx = m_idx;
            if (exp_timeout) begin
               m_e.data = FP_QNAN; m_e.zero = 1'b0; m_e.inf = 1'b0; m_e.err = 1'b1;
            end else begin
               m_e.data = m_r[31:0]; m_e.zero = m_r[33]; m_e.inf = m_r[32]; m_e.err = 1'b0;
            end
            sb.push_back(m_e);
            grant_log.push_back(m_idx);
            acc_cyc = cyc;
         end
         if (rsp_valid !== '0 && !rv_prev) begin
            rsp_cyc  = cyc;
            rsp_seen = 1'b1;
         end
         rv_prev = |rsp_valid;
         if ((rsp_valid & rsp_ready) !== '0) begin
            hs_cyc = cyc + 1;
            n_rsp++;
            n_checks++;
            if (sb.size() == 0) begin
               n_errors++;
               $display("FAIL rsp_unexpected rsp_valid=%b data=%h with no outstanding op", rsp_valid, rsp_data);
            end else begin
               m_e = sb.pop_front();
               if ({rsp_valid, rsp_data, rsp_zero, rsp_inf, rsp_err} !==
                   {4'(1) << m_e.idx, m_e.data, m_e.zero, m_e.inf, m_e.err}) begin
                  n_errors++;
                  $display("FAIL rsp_scoreboard got valid=%b data=%h z=%b i=%b e=%b required valid=%b data=%h z=%b i=%b e=%b",
                           rsp_valid, rsp_data, rsp_zero, rsp_inf, rsp_err,
                           4'(1) << m_e.idx, m_e.data, m_e.zero, m_e.inf, m_e.err);
               end
            end
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic wait_grant(input int n_before);
      int t;
      for (t = 0; t < 60 && grant_log.size() <= n_before; t++) tick();
      if (grant_log.size() <= n_before) begin
         n_checks++; n_errors++;
         $display("FAIL grant_timeout got no accept within 60 cycles, required one");
      end
   endtask

   task automatic wait_rsp();
      int t;
      for (t = 0; t < 60 && !rsp_seen; t++) tick();
      if (!rsp_seen) begin
         n_checks++; n_errors++;
         $display("FAIL rsp_timeout got no rsp_valid within 60 cycles, required one");
      end
   endtask

   task automatic wait_idle();
      int t;
      for (t = 0; t < 100 && (sb.size() != 0 || rsp_valid !== '0); t++) tick();
      if (sb.size() != 0 || rsp_valid !== '0) begin
         n_checks++; n_errors++;
         $display("FAIL idle_timeout got outstanding=%0d rsp_valid=%b required 0 and 0", sb.size(), rsp_valid);
      end
   endtask

   task automatic test_reset();
      RST = 1'b0; req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
      repeat (3) @(posedge CLK);
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_zero, rsp_inf, rsp_err, mul_A, mul_B, mul_EN} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs got rr=%b rv=%b d=%h A=%h B=%h en=%b required all zero",
                  req_ready, rsp_valid, rsp_data, mul_A, mul_B, mul_EN);
      end
      RST = 1'b1;
      tick(); tick();
   endtask

   task automatic test_round_robin();
      int n0, t;
      grant_log.delete();
      n0 = n_rsp;
      for (int i = 0; i < NREQ; i++) begin
         req_a[i*W +: W] = 32'h40000000 + 32'(i);
         req_b[i*W +: W] = 32'h3FC00000 + 32'(i * 16);
      end
      rsp_ready = '1;
      req_valid = '1;
      for (t = 0; t < 300 && (n_rsp - n0) < 5; t++) begin
         tick();
         if (grant_log.size() >= 5) req_valid = '0;
      end
      req_valid = '0;
      wait_idle();
      rsp_ready = '0;
      n_checks++;
      if (grant_log.size() != 5) begin
         n_errors++;
         $display("FAIL rr_count got %0d grants required 5", grant_log.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (grant_log[i] != i % 4) begin
               n_errors++;
               $display("FAIL rr_order[%0d] got %0d required %0d", i, grant_log[i], i % 4);
            end
         end
      end
   endtask

   task automatic test_single_op();
      int n;
      req_a[1*W +: W] = 32'h41B26666;
      req_b[1*W +: W] = 32'hBF000000;
      rsp_seen = 1'b0;
      n = grant_log.size();
      req_valid = 4'b0010;
      wait_grant(n);
      req_valid = '0;
      rsp_ready = 4'b1101;
      wait_rsp();
      n_checks++;
      if (rsp_cyc - acc_cyc != 5) begin
         n_errors++;
         $display("FAIL op_latency got %0d cycles required 5", rsp_cyc - acc_cyc);
      end
      n_checks++;
      if (rsp_valid !== 4'b0010 || rsp_data !== 32'hC1326666) begin
         n_errors++;
         $display("FAIL op_product got valid=%b data=%h required 0010 c1326666", rsp_valid, rsp_data);
      end
      repeat (3) tick();
      n_checks++;
      if (rsp_valid !== 4'b0010) begin
         n_errors++;
         $display("FAIL foreign_ready got rsp_valid=%b required 0010", rsp_valid);
      end
      rsp_ready = 4'b0010;
      wait_idle();
      rsp_ready = '0;
   endtask

   task automatic test_infinity();
      int n;
      req_a[2*W +: W] = 32'h7F800000;
      req_b[2*W +: W] = 32'h404CCCCC;
      rsp_seen = 1'b0;
      n = grant_log.size();
      req_valid = 4'b0100;
      wait_grant(n);
      req_valid = '0;
      wait_rsp();
      n_checks++;
      if ({rsp_valid, rsp_data, rsp_zero, rsp_inf} !== {4'b0100, 32'h7F800000, 1'b0, 1'b1}) begin
         n_errors++;
         $display("FAIL inf_flag got valid=%b data=%h z=%b i=%b required 0100 7f800000 0 1",
                  rsp_valid, rsp_data, rsp_zero, rsp_inf);
      end
      rsp_ready = 4'b0100;
      wait_idle();
      rsp_ready = '0;
   endtask

   task automatic test_backpressure();
      int n;
      logic [33:0] e;
      req_a[3*W +: W] = 32'h3FA00000;
      req_b[3*W +: W] = 32'h40400000;
      req_a[0*W +: W] = 32'h3E800000;
      req_b[0*W +: W] = 32'h41200000;
      e = mdl_mul(32'h3FA00000, 32'h40400000);
      rsp_seen = 1'b0;
      n = grant_log.size();
      req_valid = 4'b1000;
      wait_grant(n);
      req_valid = 4'b0001;
      wait_rsp();
      for (int i = 0; i < 10; i++) begin
         tick();
         n_checks++;
         if (rsp_valid !== 4'b1000 || rsp_data !== e[31:0] || req_ready !== '0) begin
            n_errors++;
            $display("FAIL hold_stable[%0d] got valid=%b data=%h rr=%b required 1000 %h 0000",
                     i, rsp_valid, rsp_data, req_ready, e[31:0]);
         end
      end
      n = grant_log.size();
      rsp_ready = 4'b1000;
      tick();
      rsp_ready = '0;
      wait_grant(n);
      req_valid = '0;
      n_checks++;
      if (grant_log[grant_log.size()-1] != 0 || acc_cyc != hs_cyc + 1) begin
         n_errors++;
         $display("FAIL next_grant got req%0d at +%0d required req0 at +1",
                  grant_log[grant_log.size()-1], acc_cyc - hs_cyc);
      end
      rsp_ready = 4'b0001;
      wait_idle();
      rsp_ready = '0;
   endtask

`ifdef FP_MUL_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      mdl_hang = 1'b1;
      exp_timeout = 1'b1;
      req_a[2*W +: W] = 32'h40000000;
      req_b[2*W +: W] = 32'h40000000;
      rsp_seen = 1'b0;
      n = grant_log.size();
      req_valid = 4'b0100;
      wait_grant(n);
      req_valid = '0;
      wait_rsp();
      n_checks++;
      if (rsp_cyc - acc_cyc != 17) begin
         n_errors++;
         $display("FAIL timeout_latency got %0d cycles required 17", rsp_cyc - acc_cyc);
      end
      n_checks++;
      if ({rsp_err, rsp_data} !== {1'b1, 32'h7FC00000}) begin
         n_errors++;
         $display("FAIL timeout_result got err=%b data=%h required 1 7fc00000", rsp_err, rsp_data);
      end
      rsp_ready = 4'b0100;
      wait_idle();
      rsp_ready = '0;
      mdl_hang = 1'b0;
      exp_timeout = 1'b0;
   endtask
`endif

   task automatic test_reset_mid_op();
      int n;
      mdl_hang = 1'b1;
      req_a[1*W +: W] = 32'h40800000;
      req_b[1*W +: W] = 32'h40A00000;
      n = grant_log.size();
      req_valid = 4'b0010;
      wait_grant(n);
      req_valid = '0;
      repeat (3) tick();
      n_checks++;
      if (mul_EN !== 1'b1) begin
         n_errors++;
         $display("FAIL wait_enable got mul_EN=%b required 1", mul_EN);
      end
      #2;
      RST = 1'b0;
      #1;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_data, rsp_zero, rsp_inf, rsp_err, mul_A, mul_B, mul_EN} !== '0) begin
         n_errors++;
         $display("FAIL async_reset got rv=%b d=%h A=%h B=%h en=%b required all zero",
                  rsp_valid, rsp_data, mul_A, mul_B, mul_EN);
      end
      sb.delete();
      repeat (2) tick();
      RST = 1'b1;
      mdl_hang = 1'b0;
      repeat (3) tick();
      n_checks++;
      if (rsp_valid !== '0) begin
         n_errors++;
         $display("FAIL dropped_op got rsp_valid=%b required 0000", rsp_valid);
      end
      n = grant_log.size();
      rsp_ready = '1;
      req_valid = '1;
      wait_grant(n);
      req_valid = '0;
      n_checks++;
      if (grant_log[grant_log.size()-1] != 0) begin
         n_errors++;
         $display("FAIL post_reset_grant got req%0d required req0", grant_log[grant_log.size()-1]);
      end
      wait_idle();
      rsp_ready = '0;
   endtask

   initial begin
      test_reset();
      test_round_robin();
      test_single_op();
      test_infinity();
      test_backpressure();
`ifdef FP_MUL_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_op();
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
